// File: rtl/load_store_unit_pkg.sv
// Shared encodings for the load/store unit: control codes, FSM states, access sizes.
// Purely declarative; no latency or backpressure of its own.
package load_store_unit_pkg;

   localparam logic [5:0] LB  = 6'b010011;
   localparam logic [5:0] LH  = 6'b010100;
   localparam logic [5:0] LW  = 6'b010101;
   localparam logic [5:0] LBU = 6'b010110;
   localparam logic [5:0] LHU = 6'b010111;
   localparam logic [5:0] SB  = 6'b011000;
   localparam logic [5:0] SH  = 6'b011001;
   localparam logic [5:0] SW  = 6'b011010;

   typedef enum logic [1:0] {IDLE, BEAT0, BEAT1, RESP} state_e;
   typedef enum logic [1:0] {SZ_B, SZ_H, SZ_W, SZ_X} size_e;

   // SZ_X marks every code the unit does not support.
   function automatic size_e size_of(input logic [5:0] c);
      case (c)
         LB, LBU, SB: size_of = SZ_B;
         LH, LHU, SH: size_of = SZ_H;
         LW, SW:      size_of = SZ_W;
         default:     size_of = SZ_X;
      endcase
   endfunction

endpackage

// File: rtl/load_store_unit_lsu_align.sv
// Combinational lane logic: byte enables, split detection, store shift, load extract/extend.
// Zero latency; no handshake, follows its inputs.
module lsu_align
   import load_store_unit_pkg::*;
(
   input  logic [5:0]  control,
   input  logic [1:0]  off,
   input  logic [31:0] wdata,
   input  logic [31:0] lo,
   input  logic [31:0] hi,
   output logic        legal,
   output logic        is_store,
   output logic        split,
   output logic [7:0]  be,
   output logic [63:0] st_data,
   output logic [31:0] ld_data
);

   size_e       size;
   logic [3:0]  m;
   logic [63:0] l;

   always_comb begin
      size     = size_of(control);
      legal    = (size != SZ_X);
      is_store = (control == SB) || (control == SH) || (control == SW);
      case (size)
         SZ_B:    m = 4'b0001;
         SZ_H:    m = 4'b0011;
         SZ_W:    m = 4'b1111;
         default: m = 4'b0000;
      endcase
      be      = {4'b0000, m} << off;
      split   = ((size == SZ_H) && (off == 2'd3)) || ((size == SZ_W) && (off != 2'd0));
      st_data = {32'b0, wdata} << {off, 3'b000};
      // hi is zero for unsplit accesses, so the same shift serves both cases.
      l       = {hi, lo} >> {off, 3'b000};
      case (control)
         LB:      ld_data = {{24{l[7]}}, l[7:0]};
         LBU:     ld_data = {24'b0, l[7:0]};
         LH:      ld_data = {{16{l[15]}}, l[15:0]};
         LHU:     ld_data = {16'b0, l[15:0]};
         default: ld_data = l[31:0];
      endcase
   end

endmodule

// File: rtl/load_store_unit.sv
// Load/store initiator: one command -> one or two word beats on a req/ready memory port.
// 3 cycles start-to-done aligned, 4 split, +1 per mem_ready stall; starts while busy are dropped.
module load_store_unit
   import load_store_unit_pkg::*;
#(
   parameter int ADDR_W = 32,
   parameter int DATA_W = 32
) (
   input  logic              clk,
   input  logic              rst,
   input  logic              start,
   input  logic [5:0]        control,
   input  logic [ADDR_W-1:0] addr,
   input  logic [DATA_W-1:0] wdata,
   output logic              busy,
   output logic              done,
   output logic              err,
   output logic [DATA_W-1:0] rdata,
   output logic              mem_req,
   output logic              mem_we,
   output logic [ADDR_W-1:0] mem_addr,
   output logic [3:0]        mem_be,
   output logic [DATA_W-1:0] mem_wdata,
   input  logic              mem_ready,
   input  logic [DATA_W-1:0] mem_rdata
);

   state_e            state;
   logic [5:0]        ctrl_q;
   logic [1:0]        off_q;
   logic [DATA_W-1:0] wdata_q;
   logic [DATA_W-1:0] lo_q;

   logic [5:0]        a_ctrl;
   logic [1:0]        a_off;
   logic [DATA_W-1:0] a_wdata, a_lo, a_hi;
   logic              legal, is_store, split;
   logic [7:0]        be;
   logic [63:0]       st_data;
   logic [31:0]       ld_data;

   // In IDLE the first beat is built from the live command so it can be registered on accept.
   assign a_ctrl  = (state == IDLE) ? control   : ctrl_q;
   assign a_off   = (state == IDLE) ? addr[1:0] : off_q;
   assign a_wdata = (state == IDLE) ? wdata     : wdata_q;
   assign a_lo    = (state == BEAT1) ? lo_q      : mem_rdata;
   assign a_hi    = (state == BEAT1) ? mem_rdata : '0;

   lsu_align u_align (
      .control  (a_ctrl),
      .off      (a_off),
      .wdata    (a_wdata),
      .lo       (a_lo),
      .hi       (a_hi),
      .legal    (legal),
      .is_store (is_store),
      .split    (split),
      .be       (be),
      .st_data  (st_data),
      .ld_data  (ld_data)
   );

   always_ff @(posedge clk or negedge rst) begin
      if (!rst) begin
         state     <= IDLE;
         busy      <= 1'b0;
         done      <= 1'b0;
         err       <= 1'b0;
         mem_req   <= 1'b0;
         mem_we    <= 1'b0;
         mem_addr  <= '0;
         mem_be    <= '0;
         mem_wdata <= '0;
         rdata     <= '0;
         ctrl_q    <= '0;
         off_q     <= '0;
         wdata_q   <= '0;
         lo_q      <= '0;
      end else begin
         case (state)
            IDLE: if (start) begin
               ctrl_q  <= control;
               off_q   <= addr[1:0];
               wdata_q <= wdata;
               busy    <= 1'b1;
               if (legal) begin
                  state     <= BEAT0;
                  mem_req   <= 1'b1;
                  mem_we    <= is_store;
                  mem_addr  <= {addr[ADDR_W-1:2], 2'b00};
                  mem_be    <= be[3:0];
                  mem_wdata <= st_data[31:0];
               end else begin
                  state <= RESP;
                  done  <= 1'b1;
                  err   <= 1'b1;
               end
            end
            BEAT0: if (mem_ready) begin
               lo_q <= mem_rdata;
               if (split) begin
                  state     <= BEAT1;
                  mem_addr  <= mem_addr + ADDR_W'(4);
                  mem_be    <= be[7:4];
                  mem_wdata <= st_data[63:32];
               end else begin
                  state   <= RESP;
                  mem_req <= 1'b0;
                  mem_we  <= 1'b0;
                  done    <= 1'b1;
                  if (!is_store) rdata <= ld_data;
               end
            end
            BEAT1: if (mem_ready) begin
               state   <= RESP;
               mem_req <= 1'b0;
               mem_we  <= 1'b0;
               done    <= 1'b1;
               if (!is_store) rdata <= ld_data;
            end
            RESP: begin
               state <= IDLE;
               busy  <= 1'b0;
               done  <= 1'b0;
               err   <= 1'b0;
            end
            default: state <= IDLE;
         endcase
      end
   end

endmodule

// File: tb/tb_load_store_unit.sv
// Bench for load_store_unit: directed vector table, reset corner cases, then random traffic
// checked against a byte-addressed memory model.
`timescale 1ns/1ps
module tb_load_store_unit;
   import load_store_unit_pkg::*;

   logic        clk = 1'b0, rst = 1'b0, start = 1'b0;
   logic [5:0]  control = '0;
   logic [31:0] addr = '0, wdata = '0;
   logic        busy, done, err, mem_req, mem_we;
   logic [31:0] rdata, mem_addr, mem_wdata;
   logic [3:0]  mem_be;
   logic        mem_ready = 1'b1;
   logic [31:0] mem_rdata = '0;

   always #5 clk = ~clk;

   load_store_unit dut (
      .clk(clk), .rst(rst), .start(start), .control(control), .addr(addr), .wdata(wdata),
      .busy(busy), .done(done), .err(err), .rdata(rdata),
      .mem_req(mem_req), .mem_we(mem_we), .mem_addr(mem_addr), .mem_be(mem_be),
      .mem_wdata(mem_wdata), .mem_ready(mem_ready), .mem_rdata(mem_rdata)
   );

   int checks = 0, errors = 0;
   logic [31:0] mem [logic [31:0]];
   int          stall_cfg = 0, wcnt = 0, beats_total = 0, base = 0, viol = 0;
   logic [31:0] b_addr [2];
   logic [3:0]  b_be [2];
   logic [31:0] b_wd [2];
   logic        pw = 1'b0;
   logic [69:0] prev_o = '0;
   logic [31:0] last_rd = '0;

   function automatic logic [31:0] rd_word(input logic [31:0] a);
      if (mem.exists(a)) return mem[a];
      return a ^ 32'hA5C3_0F96;
   endfunction

   function automatic logic [7:0] mem_byte(input logic [31:0] a);
      logic [31:0] w;
      w = rd_word({a[31:2], 2'b00});
      return w[8*a[1:0] +: 8];
   endfunction

   function automatic int nbytes(input logic [5:0] c);
      case (c)
         LB, LBU, SB: return 1;
         LH, LHU, SH: return 2;
         LW, SW:      return 4;
         default:     return 0;
      endcase
   endfunction

   function automatic bit is_st(input logic [5:0] c);
      return (c == SB) || (c == SH) || (c == SW);
   endfunction

   // Little-endian read of consecutive byte addresses, then extension by opcode.
   function automatic logic [31:0] exp_load(input logic [5:0] c, input logic [31:0] a);
      logic [7:0] b [4];
      for (int i = 0; i < 4; i++) b[i] = mem_byte(a + 32'(i));
      case (c)
         LB:      return {{24{b[0][7]}}, b[0]};
         LBU:     return {24'h0, b[0]};
         LH:      return {{16{b[1][7]}}, b[1], b[0]};
         LHU:     return {16'h0, b[1], b[0]};
         default: return {b[3], b[2], b[1], b[0]};
      endcase
   endfunction

   // Responder: ready after stall_cfg wait cycles on each request, byte-lane writes into mem.
   always @(negedge clk) begin
      wcnt      = mem_req ? wcnt + 1 : 0;
      mem_ready = !mem_req || (wcnt > stall_cfg);
      mem_rdata = rd_word(mem_addr);
   end

   always @(posedge clk) begin
      if (rst && mem_req && mem_ready) begin
         int k;
         logic [31:0] w;
         k = beats_total - base;
         if (k >= 0 && k < 2) begin
            b_addr[k] = mem_addr; b_be[k] = mem_be; b_wd[k] = mem_wdata;
         end
         beats_total++;
         if (mem_we) begin
            w = rd_word(mem_addr);
            for (int i = 0; i < 4; i++) if (mem_be[i]) w[8*i +: 8] = mem_wdata[8*i +: 8];
            mem[mem_addr] = w;
         end
      end
      if (!rst) pw = 1'b0;
      else begin
         if (pw && ({mem_req, mem_we, mem_addr, mem_be, mem_wdata} != prev_o)) viol++;
         if (mem_req && (mem_addr[1:0] != 2'b00)) viol++;
         pw     = mem_req && !mem_ready;
         prev_o = {mem_req, mem_we, mem_addr, mem_be, mem_wdata};
      end
   end

   task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
      checks++;
      if (act !== exp) begin
         errors++;
         $display("FAIL %s: actual=%h required=%h", name, act, exp);
      end
   endtask

   // cyc counts the start cycle as 1; poke re-asserts start (SB to 0x80) in that cycle.
   task automatic run_txn(input logic [5:0] c, input logic [31:0] a, input logic [31:0] wd,
                          input int stall, input int poke, input string tag,
                          output int cyc, output logic got_err, output logic [31:0] got_rd,
                          output int nb);
      @(negedge clk);
      stall_cfg = stall; base = beats_total;
      start = 1'b1; control = c; addr = a; wdata = wd;
      cyc = 1;
      do begin
         @(negedge clk);
         cyc++;
         start = (cyc == poke);
         if (start) begin control = SB; addr = 32'h80; wdata = 32'h5A; end
      end while (!done && cyc < 100);
      got_err = err; got_rd = rdata; nb = beats_total - base;
      @(negedge clk);
      start = 1'b0;
      chk({tag, " busy after done"}, busy, 0);
      chk({tag, " done width"}, done, 0);
   endtask

   typedef struct {
      logic [5:0] c; logic [31:0] a; logic [31:0] wd; int stall; int poke;
      logic [31:0] rd; logic er; int cyc; int nb;
      logic [3:0] be0; logic [31:0] wd0; logic [3:0] be1; logic [31:0] wd1;
   } vec_t;
   vec_t tbl [16];

   initial begin
      #1ms;
      $display("FAIL watchdog: simulation time limit reached");
      $fatal(1);
   end

   initial begin
      tbl[0]  = '{SW,  32'h10, 32'h3BCA75AC, 0, -1, 32'h00000000, 1'b0, 3, 1, 4'hF, 32'h3BCA75AC, 4'h0, 32'h0};
      tbl[1]  = '{LW,  32'h10, 32'h0,        0, -1, 32'h3BCA75AC, 1'b0, 3, 1, 4'hF, 32'h0, 4'h0, 32'h0};
      tbl[2]  = '{LB,  32'h13, 32'h0,        0, -1, 32'h0000003B, 1'b0, 3, 1, 4'h8, 32'h0, 4'h0, 32'h0};
      tbl[3]  = '{SB,  32'h13, 32'h00000095, 0, -1, 32'h0000003B, 1'b0, 3, 1, 4'h8, 32'h95000000, 4'h0, 32'h0};
      tbl[4]  = '{LB,  32'h13, 32'h0,        0, -1, 32'hFFFFFF95, 1'b0, 3, 1, 4'h8, 32'h0, 4'h0, 32'h0};
      tbl[5]  = '{LBU, 32'h13, 32'h0,        0, -1, 32'h00000095, 1'b0, 3, 1, 4'h8, 32'h0, 4'h0, 32'h0};
      tbl[6]  = '{LHU, 32'h11, 32'h0,        0, -1, 32'h0000CA75, 1'b0, 3, 1, 4'h6, 32'h0, 4'h0, 32'h0};
      tbl[7]  = '{LH,  32'h11, 32'h0,        0, -1, 32'hFFFFCA75, 1'b0, 3, 1, 4'h6, 32'h0, 4'h0, 32'h0};
      tbl[8]  = '{SH,  32'h07, 32'h0000BEEF, 0, -1, 32'hFFFFCA75, 1'b0, 4, 2, 4'h8, 32'hEF000000, 4'h1, 32'h000000BE};
      tbl[9]  = '{SW,  32'hFFFFFFFC, 32'h11223344, 0, -1, 32'hFFFFCA75, 1'b0, 3, 1, 4'hF, 32'h11223344, 4'h0, 32'h0};
      tbl[10] = '{SW,  32'h0, 32'h55667788,  0, -1, 32'hFFFFCA75, 1'b0, 3, 1, 4'hF, 32'h55667788, 4'h0, 32'h0};
      tbl[11] = '{LW,  32'hFFFFFFFE, 32'h0,  0, -1, 32'h77881122, 1'b0, 4, 2, 4'hC, 32'h0, 4'h3, 32'h0};
      tbl[12] = '{6'b000000, 32'h40, 32'h0,  0, -1, 32'h77881122, 1'b1, 2, 0, 4'h0, 32'h0, 4'h0, 32'h0};
      tbl[13] = '{SW,  32'h21, 32'hDEADBEEF, 0, -1, 32'h77881122, 1'b0, 4, 2, 4'hE, 32'hADBEEF00, 4'h1, 32'h000000DE};
      tbl[14] = '{LW,  32'h10, 32'h0,        5,  4, 32'h95CA75AC, 1'b0, 8, 1, 4'hF, 32'h0, 4'h0, 32'h0};
      tbl[15] = '{LB,  32'h12, 32'h0,        0,  3, 32'hFFFFFFCA, 1'b0, 3, 1, 4'h4, 32'h0, 4'h0, 32'h0};

      repeat (2) @(negedge clk);
      chk("reset ctrl outputs", {27'b0, busy, done, err, mem_req, mem_we}, 0);
      chk("reset mem_addr", mem_addr, 0);
      chk("reset mem_be", mem_be, 0);
      chk("reset mem_wdata", mem_wdata, 0);
      chk("reset rdata", rdata, 0);
      rst = 1'b1;

      for (int i = 0; i < 16; i++) begin
         vec_t v;
         int cyc, nb;
         logic ge;
         logic [31:0] gr, wa;
         v = tbl[i];
         run_txn(v.c, v.a, v.wd, v.stall, v.poke, $sformatf("row%0d", i), cyc, ge, gr, nb);
         chk($sformatf("row%0d cycles", i), cyc, v.cyc);
         chk($sformatf("row%0d err", i), ge, v.er);
         chk($sformatf("row%0d rdata", i), gr, v.rd);
         chk($sformatf("row%0d beats", i), nb, v.nb);
         wa = {v.a[31:2], 2'b00};
         if (nb >= 1) begin
            chk($sformatf("row%0d beat0 addr", i), b_addr[0], wa);
            chk($sformatf("row%0d beat0 be", i), b_be[0], v.be0);
            if (is_st(v.c)) chk($sformatf("row%0d beat0 wdata", i), b_wd[0], v.wd0);
         end
         if (nb >= 2) begin
            chk($sformatf("row%0d beat1 addr", i), b_addr[1], wa + 32'd4);
            chk($sformatf("row%0d beat1 be", i), b_be[1], v.be1);
            if (is_st(v.c)) chk($sformatf("row%0d beat1 wdata", i), b_wd[1], v.wd1);
         end
      end
      last_rd = tbl[15].rd;

      // Reset while the second beat of a split store is outstanding.
      begin
         logic saw;
         @(negedge clk);
         stall_cfg = 0; start = 1'b1; control = SW; addr = 32'h21; wdata = 32'hCAFEF00D;
         @(negedge clk);
         start = 1'b0;
         @(negedge clk);
         chk("beat1 req before reset", mem_req, 1);
         rst = 1'b0;
         #1;
         chk("mem_req after async reset", mem_req, 0);
         chk("busy after async reset", busy, 0);
         saw = 1'b0;
         repeat (3) begin @(negedge clk); saw |= done; end
         chk("no done across reset", saw, 0);
         rst = 1'b1;
         @(negedge clk);
         chk("rdata cleared by reset", rdata, 0);
         last_rd = '0;
      end

      for (int k = 0; k < 200; k++) begin
         logic [5:0]  codes [8];
         logic [5:0]  c;
         logic [31:0] a, wd, er, gr;
         int n, eb, ecyc, stall, poke, cyc, nb;
         logic ge;
         codes = '{LB, LH, LW, LBU, LHU, SB, SH, SW};
         c     = ($urandom_range(0, 9) == 0) ? 6'($urandom_range(0, 18)) : codes[$urandom_range(0, 7)];
         a     = ($urandom_range(0, 3) == 0) ? 32'hFFFFFFF8 + $urandom_range(0, 7) : $urandom_range(0, 63);
         wd    = $urandom;
         stall = $urandom_range(0, 2);
         poke  = ($urandom_range(0, 3) == 0) ? int'($urandom_range(2, 6)) : -1;
         n     = nbytes(c);
         eb    = (n == 0) ? 0 : ((int'(a[1:0]) + n > 4) ? 2 : 1);
         ecyc  = (n == 0) ? 2 : 2 + eb + stall;
         er    = (n > 0 && !is_st(c)) ? exp_load(c, a) : last_rd;
         run_txn(c, a, wd, stall, poke, $sformatf("rand%0d", k), cyc, ge, gr, nb);
         chk($sformatf("rand%0d cycles", k), cyc, ecyc);
         chk($sformatf("rand%0d err", k), ge, (n == 0));
         chk($sformatf("rand%0d rdata", k), gr, er);
         chk($sformatf("rand%0d beats", k), nb, eb);
         if (n > 0 && is_st(c))
            for (int i = 0; i < n; i++)
               chk($sformatf("rand%0d byte%0d", k, i), mem_byte(a + 32'(i)), wd[8*i +: 8]);
         last_rd = er;
      end

      chk("handshake stability", viol, 0);
      chk("dropped start wrote memory", mem.exists(32'h80), 0);
      $display("Simulation finished: %0d checks, %0d errors", checks, errors);
      $finish;
   end

endmodule

// File: doc/load_store_unit.md
Name: load_store_unit

Overview:
- Initiator side of the data-memory interface: takes one load/store command per transaction from the single-cycle core and drives a word-addressed, byte-lane memory port with a req/ready handshake.
- Handles byte/half/word sizes, sign/zero extension, lane alignment, and splitting of misaligned accesses that straddle a word boundary into two beats.
- Sits between the core's execute/writeback path and the data memory.

Parameters:
- ADDR_W, 32, byte-address width on both sides
- DATA_W, 32, data width; fixed at 32 (4 byte lanes)

Ports:
- clk  in  1  single clock, rising edge
- rst  in  1  asynchronous, active-low reset (rst=0 resets)
- start  in  1  command valid for one cycle; ignored while busy=1
- control  in  6  operation code (see Decomposition)
- addr  in  32  byte address
- wdata  in  32  store data, right-aligned
- busy  out  1  transaction in progress
- done  out  1  one-cycle completion pulse
- err  out  1  valid with done; 1 = unsupported control code
- rdata  out  32  extended load result; held until the next done
- mem_req  out  1  memory request valid
- mem_we  out  1  1 = write beat
- mem_addr  out  32  word-aligned address, bits [1:0]=0
- mem_be  out  4  byte-lane enables
- mem_wdata  out  32  lane-positioned write data
- mem_ready  in  1  responder accepts/completes the beat this cycle
- mem_rdata  in  32  read data, valid when mem_req and mem_ready are both 1

Behaviour:
- Reset (rst=0, asynchronous): state=IDLE; busy, done, err, mem_req, mem_we = 0; mem_addr, mem_be, mem_wdata, rdata = 0. A reset during any state aborts the transaction immediately, with no done pulse. The captured first-beat data is discarded.
- On a start in IDLE, the unit registers control, addr and wdata. off = addr[1:0].
- States and transitions:
  - IDLE → BEAT0 on start with a legal code.
  - IDLE → RESP on start with an illegal code; err=1, no memory traffic.
  - BEAT0: mem_req=1, mem_addr = {addr[31:2],2'b00}. Hold all outputs stable until mem_ready=1.
    - On mem_ready: → BEAT1 if split, else → RESP.
    - For loads, mem_rdata is captured as lo.
  - BEAT1: mem_req=1, mem_addr = BEAT0 address + 4, modulo 2^32 (0xFFFFFFFC wraps to 0x0). On mem_ready: capture hi, → RESP.
  - RESP: done=1 for exactly one cycle; rdata updated in the same cycle. → IDLE.
- busy=1 in BEAT0, BEAT1 and RESP.
- A start asserted during busy is dropped, not queued.
- A start in the same cycle that the unit returns to IDLE is also dropped; the first start accepted is the one seen in IDLE.
- Split rule: a half access splits when off=3; a word access splits when off≠0; a byte access never splits.
- Lane mask m: byte=4'b0001, half=4'b0011, word=4'b1111.
  - 8-bit shifted mask M = m << off.
  - BEAT0 mem_be = M[3:0]; BEAT1 mem_be = M[7:4].
- Store data: 64-bit S = {32'b0, wdata} << (8*off).
  - BEAT0 mem_wdata = S[31:0]; BEAT1 mem_wdata = S[63:32].
  - mem_we = 1 for stores, 0 for loads.
- Load data: 64-bit L = {hi, lo} >> (8*off); hi = 0 if there is no split.
  - LB: sign-extend L[7:0]. LBU: zero-extend L[7:0].
  - LH: sign-extend L[15:0]. LHU: zero-extend L[15:0].
  - LW: L[31:0].
- Stores leave rdata unchanged.
- Latency with mem_ready tied high: aligned access = 3 cycles from start to done; split access = 4 cycles. Each wait cycle on mem_ready adds one cycle.
- mem_req never drops while waiting for mem_ready. Address, enables and data do not change while mem_req=1 and mem_ready=0.

Decomposition:
- Shared package holds:
  - Control codes LB=6'b010011, LH=6'b010100, LW=6'b010101, LBU=6'b010110, LHU=6'b010111, SB=6'b011000, SH=6'b011001, SW=6'b011010.
  - State encoding IDLE/BEAT0/BEAT1/RESP.
  - Size encoding.
- One natural sub-module, lsu_align: purely combinational. It derives lane mask, split flag, shifted store data, and load extraction/extension from control, off, wdata, lo and hi. The FSM and handshake stay in load_store_unit.

Test Plan:
- LW addr=0x10, mem_ready=1, mem_rdata=0x3BCA75AC → one beat, mem_be=4'b1111, mem_addr=0x10; done on cycle 3; rdata=0x3BCA75AC, err=0.
- LB addr=0x13 with word 0x3BCA75AC → mem_be=4'b1000; rdata=0x0000003B. Repeat with word 0x95CA75AC: LB → 0xFFFFFF95, LBU → 0x00000095.
- SH addr=0x07, wdata=0x0000BEEF → BEAT0 at 0x04, be=4'b1000, wdata=0xEF000000; BEAT1 at 0x08, be=4'b0001, wdata=0x000000BE; done on cycle 4.
- LW addr=0xFFFFFFFE, lo=0x11223344, hi=0x55667788 → BEAT1 mem_addr=0x00000000; rdata=0x77881122.
- mem_ready held low 5 cycles in BEAT0 → mem_req, mem_addr, mem_be stable throughout; a start pulse mid-wait is ignored; done occurs 5 cycles later than nominal.
- Reset mid-BEAT1: rst=0 → mem_req and busy drop asynchronously, no done. Illegal control=6'b000000 → done with err=1, mem_req never asserted.
